pll_scan_engine: RTL and testbench
==================================

# pll_scan_engine

Scan-chain engine that sits between the frequency-synthesizer control FSM and the PLL's serial reconfiguration port. It accepts counter-parameter writes and reconfiguration requests over the `write_param`/`reconfig`/`busy` handshake and holds a shadow copy of the N, M and C0 counter settings. On request it serialises those settings into the PLL scan chain, pulses `configupdate`, and waits for `scandone`.

## Interface
- `SCANCLK_DIV`, default 2: number of `clk` cycles per `scanclk` half-period; legal range ≥1.
- `DONE_TIMEOUT`, default 1023: maximum number of `clk` cycles spent in WAIT_DONE before the engine aborts.
- `clk` in 1: system clock. Every register is clocked on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `write_param` in 1: one-cycle strobe; writes `data_in` into the shadow field selected by `counter_type`/`counter_param`.
- `reconfig` in 1: one-cycle strobe; starts a scan-chain load.
- `counter_type` in 4: 0000 = N, 0001 = M, 0100 = C0. Other codes are ignored.
- `counter_param` in 3: 000 = high count, 001 = low count, 100 = bypass, 101 = odd/even, 111 = nominal count. Other codes are ignored.
- `data_in` in 9: parameter value.
- `busy` out 1: engine is not accepting requests.
- `timeout` out 1: sticky flag set when WAIT_DONE expires.
- `pll_areset_in` in 1: PLL reset request.
- `pll_areset` out 1: equals `pll_areset_in` (combinational).
- `scanclk` out 1, `scanclkena` out 1, `scandata` out 1, `configupdate` out 1: PLL scan port outputs.
- `scandone` in 1: PLL scan-complete indication.

## Operation
- Each counter has a shadow record of 18 bits: {hi[7:0], bypass, lo[7:0], odd}.
- Reset values:
  - N: hi=1, lo=1, bypass=1, odd=0.
  - M: hi=6, lo=6, bypass=0, odd=0.
  - C0: hi=6, lo=6, bypass=0, odd=0.
- Write decode (data_in is 9 bits, d):
  - high count: hi=d[7:0].
  - low count: lo=d[7:0].
  - bypass: bypass=d[0].
  - odd/even: odd=d[0].
  - nominal, d≥2: hi=d[8:1]+d[0], lo=d[8:1], odd=d[0], bypass=0.
  - nominal, d=1: bypass=1; hi, lo and odd are unchanged.
  - nominal, d=0: ignored.
  - Counter value 0 in hi or lo means 256.
- Chain vector is 54 bits: {C0, M, N}. It is shifted MSB first, so C0.hi[7] goes out first and N.odd goes out last.
- FSM states: IDLE, WRITE, SHIFT, UPDATE, WAIT_DONE.
  - IDLE, `write_param` high: update the shadow record, go to WRITE. If `reconfig` is high on the same cycle it is ignored; write has priority.
  - IDLE, `reconfig` high: load the shift register from the shadow records, clear `timeout`, go to SHIFT.
  - WRITE: lasts one cycle, then IDLE.
  - SHIFT: `scanclkena`=1; `scanclk` toggles every `SCANCLK_DIV` cycles. After the 54th rising edge of `scanclk`, go to UPDATE.
  - UPDATE: lasts one full `scanclk` period, then WAIT_DONE.
  - WAIT_DONE: return to IDLE when synchronised `scandone`=1, or when `DONE_TIMEOUT` cycles have elapsed (the latter also sets `timeout`=1).
- `busy`=1 in every state except IDLE.
- Requests that arrive while `busy`=1 are dropped.
- `scandone` passes through a 2-flop synchroniser before use.
- `pll_areset_in`=1 in SHIFT, UPDATE or WAIT_DONE:
  - Abort to IDLE on the next edge.
  - Drive all scan outputs low.
  - Leave the shadow records and `timeout` unchanged.

## Timing
- Reset state:
  - Outputs: `busy`, `timeout`, `scanclk`, `scanclkena`, `scandata` and `configupdate` are all 0.
  - FSM is in IDLE; shadow records take their reset values.
- Request latency: a strobe sampled at edge k drives `busy`=1 from edge k+1.
  - A write leaves `busy` high for exactly 1 cycle.
- SHIFT timing, with SHIFT entered at edge e:
  - `scanclk`=0 and `scandata`=bit53 are driven at e.
  - Rising edge i of `scanclk` (i=1..54) occurs at e+(2i−1)·`SCANCLK_DIV`.
  - `scandata` changes only on `scanclk` falling edges, so it is stable across every rising edge.
- At e+108·`SCANCLK_DIV`:
  - `scanclkena` goes to 0 and `configupdate` goes to 1.
  - `configupdate` stays high for 2·`SCANCLK_DIV` cycles.
  - `scanclk` keeps running until the FSM returns to IDLE, then parks low.
- With `SCANCLK_DIV`=2, the minimum time from `reconfig` to `busy` falling is 1+216+4+2+`scandone` latency cycles.
- `reset` asserted at any point returns every register to its reset value immediately, with no completion of the scan in progress.

## Test plan
- After reset, issue `reconfig` with `scandone` tied high 10 cycles after `configupdate`:
  - Capture 54 bits on `scanclk` rising edges; they must equal {C0:06,0,06,0; M:06,0,06,0; N:01,1,01,0}.
  - `busy` must fall and `timeout`=0.
- Write M nominal `data_in`=13, then C0 high=0x20, then `reconfig`:
  - M shifts out as hi=7, bypass=0, lo=6, odd=1.
  - C0.hi shifts out as 0x20.
  - Each write holds `busy` high for exactly 1 cycle.
- Assert `write_param` and `reconfig` in the same cycle:
  - Only the write occurs; `busy` is 1 cycle wide; no `scanclkena`.
- Pulse `write_param` during SHIFT, then read back with a fresh scan:
  - The mid-scan write is ignored; both scans are bit-identical.
- Hold `scandone` at 0:
  - `busy` falls 1023 cycles after WAIT_DONE is entered and `timeout`=1.
  - The next `reconfig` clears `timeout`.
- Assert `pll_areset_in` at scan bit 20:
  - Next edge: IDLE with `scanclkena`/`scandata`/`configupdate`=0 and `pll_areset`=1.
  - A subsequent scan outputs the unchanged shadow records.

Source files
------------

// File: rtl/pll_scan_engine.sv
// PLL scan-chain engine: holds shadow N/M/C0 counter settings and serialises them
// into the PLL reconfiguration port, then pulses configupdate and waits for scandone.
module pll_scan_engine #(
    parameter int unsigned SCANCLK_DIV  = 2,
    parameter int unsigned DONE_TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       write_param,
    input  logic       reconfig,
    input  logic [3:0] counter_type,
    input  logic [2:0] counter_param,
    input  logic [8:0] data_in,
    output logic       busy,
    output logic       timeout,
    input  logic       pll_areset_in,
    output logic       pll_areset,
    output logic       scanclk,
    output logic       scanclkena,
    output logic       scandata,
    output logic       configupdate,
    input  logic       scandone
);

    localparam int unsigned DivW  = (SCANCLK_DIV > 1) ? $clog2(SCANCLK_DIV) : 1;
    localparam int unsigned WaitW = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;

    localparam logic [DivW-1:0]  DivLast  = DivW'(SCANCLK_DIV - 1);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(DONE_TIMEOUT - 1);
    localparam logic [5:0]       LastBit  = 6'd53;

    // Record layout: {hi[7:0], bypass, lo[7:0], odd}
    localparam logic [17:0] NReset  = {8'd1, 1'b1, 8'd1, 1'b0};
    localparam logic [17:0] MReset  = {8'd6, 1'b0, 8'd6, 1'b0};
    localparam logic [17:0] C0Reset = {8'd6, 1'b0, 8'd6, 1'b0};

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StShift,
        StUpdate,
        StWaitDone
    } state_t;

    state_t state_q, state_d;

    logic [17:0]      n_q, n_d;
    logic [17:0]      m_q, m_d;
    logic [17:0]      c0_q, c0_d;
    logic [53:0]      shift_q, shift_d;
    logic [DivW-1:0]  div_q, div_d;
    logic [5:0]       bit_q, bit_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic             sclk_q, sclk_d;
    logic             sclkena_q, sclkena_d;
    logic             sdata_q, sdata_d;
    logic             cfgupd_q, cfgupd_d;
    logic             timeout_q, timeout_d;
    logic [1:0]       done_sync_q;

    logic done_s;
    logic tick;
    logic scanning;

    function automatic logic [17:0] write_rec(input logic [17:0] rec,
                                              input logic [2:0]  param,
                                              input logic [8:0]  d);
        logic [17:0] r;
        r = rec;
        case (param)
            3'b000: r[17:10] = d[7:0];
            3'b001: r[8:1]   = d[7:0];
            3'b100: r[9]     = d[0];
            3'b101: r[0]     = d[0];
            3'b111: begin
                if (d >= 9'd2) begin
                    // Odd divide ratios put the extra cycle in the high phase
                    r[17:10] = d[8:1] + {7'd0, d[0]};
                    r[8:1]   = d[8:1];
                    r[0]     = d[0];
                    r[9]     = 1'b0;
                end else if (d == 9'd1) begin
                    r[9] = 1'b1;
                end
            end
            default: ;
        endcase
        return r;
    endfunction

    assign done_s   = done_sync_q[1];
    assign tick     = (div_q == DivLast);
    assign scanning = (state_q == StShift) || (state_q == StUpdate) || (state_q == StWaitDone);

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        m_d       = m_q;
        c0_d      = c0_q;
        shift_d   = shift_q;
        div_d     = div_q;
        bit_d     = bit_q;
        wait_d    = wait_q;
        sclk_d    = sclk_q;
        sclkena_d = sclkena_q;
        sdata_d   = sdata_q;
        cfgupd_d  = cfgupd_q;
        timeout_d = timeout_q;

        if (scanning) begin
            div_d = tick ? '0 : div_q + DivW'(1);
            if (tick) begin
                sclk_d = ~sclk_q;
            end
        end

        unique case (state_q)
            StIdle: begin
                sclk_d    = 1'b0;
                sclkena_d = 1'b0;
                sdata_d   = 1'b0;
                cfgupd_d  = 1'b0;
                div_d     = '0;
                if (write_param) begin
                    unique case (counter_type)
                        4'b0000: n_d  = write_rec(n_q, counter_param, data_in);
                        4'b0001: m_d  = write_rec(m_q, counter_param, data_in);
                        4'b0100: c0_d = write_rec(c0_q, counter_param, data_in);
                        default: ;
                    endcase
                    state_d = StWrite;
                end else if (reconfig) begin
                    shift_d   = {c0_q, m_q, n_q};
                    sdata_d   = c0_q[17];
                    sclkena_d = 1'b1;
                    bit_d     = '0;
                    timeout_d = 1'b0;
                    state_d   = StShift;
                end
            end
            StWrite: begin
                state_d = StIdle;
            end
            StShift: begin
                // Data advances on scanclk falling edges so it is stable at each rise
                if (tick && sclk_q) begin
                    if (bit_q == LastBit) begin
                        sclkena_d = 1'b0;
                        sdata_d   = 1'b0;
                        cfgupd_d  = 1'b1;
                        state_d   = StUpdate;
                    end else begin
                        shift_d = {shift_q[52:0], 1'b0};
                        sdata_d = shift_q[52];
                        bit_d   = bit_q + 6'd1;
                    end
                end
            end
            StUpdate: begin
                if (tick && sclk_q) begin
                    cfgupd_d = 1'b0;
                    wait_d   = '0;
                    state_d  = StWaitDone;
                end
            end
            StWaitDone: begin
                if (done_s) begin
                    sclk_d  = 1'b0;
                    state_d = StIdle;
                end else if (wait_q == WaitLast) begin
                    sclk_d    = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // PLL reset abandons the scan but keeps shadow records and the timeout flag
        if (scanning && pll_areset_in) begin
            state_d   = StIdle;
            sclk_d    = 1'b0;
            sclkena_d = 1'b0;
            sdata_d   = 1'b0;
            cfgupd_d  = 1'b0;
            div_d     = '0;
            timeout_d = timeout_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            n_q         <= NReset;
            m_q         <= MReset;
            c0_q        <= C0Reset;
            shift_q     <= '0;
            div_q       <= '0;
            bit_q       <= '0;
            wait_q      <= '0;
            sclk_q      <= 1'b0;
            sclkena_q   <= 1'b0;
            sdata_q     <= 1'b0;
            cfgupd_q    <= 1'b0;
            timeout_q   <= 1'b0;
            done_sync_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            m_q         <= m_d;
            c0_q        <= c0_d;
            shift_q     <= shift_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            wait_q      <= wait_d;
            sclk_q      <= sclk_d;
            sclkena_q   <= sclkena_d;
            sdata_q     <= sdata_d;
            cfgupd_q    <= cfgupd_d;
            timeout_q   <= timeout_d;
            done_sync_q <= {done_sync_q[0], scandone};
        end
    end

    assign busy         = (state_q != StIdle);
    assign timeout      = timeout_q;
    assign pll_areset   = pll_areset_in;
    assign scanclk      = sclk_q;
    assign scanclkena   = sclkena_q;
    assign scandata     = sdata_q;
    assign configupdate = cfgupd_q;

endmodule

// File: tb/tb_pll_scan_engine.sv
// Directed bench for pll_scan_engine: write/scan vector table plus hand-written
// sequences for same-cycle requests, mid-scan writes, timeout and PLL reset abort.
module tb_pll_scan_engine;

    logic       clk;
    logic       reset;
    logic       write_param;
    logic       reconfig;
    logic [3:0] counter_type;
    logic [2:0] counter_param;
    logic [8:0] data_in;
    logic       busy;
    logic       timeout;
    logic       pll_areset_in;
    logic       pll_areset;
    logic       scanclk;
    logic       scanclkena;
    logic       scandata;
    logic       configupdate;
    logic       scandone;

    int checks   = 0;
    int failures = 0;

    pll_scan_engine dut (
        .clk           (clk),
        .reset         (reset),
        .write_param   (write_param),
        .reconfig      (reconfig),
        .counter_type  (counter_type),
        .counter_param (counter_param),
        .data_in       (data_in),
        .busy          (busy),
        .timeout       (timeout),
        .pll_areset_in (pll_areset_in),
        .pll_areset    (pll_areset),
        .scanclk       (scanclk),
        .scanclkena    (scanclkena),
        .scandata      (scandata),
        .configupdate  (configupdate),
        .scandone      (scandone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ctype;
        logic [2:0]  cparam;
        logic [8:0]  data;
        logic [53:0] exp_chain;
    } vec_t;

    vec_t vecs[11];

    function automatic logic [17:0] rec(input logic [7:0] hi, input logic byp,
                                        input logic [7:0] lo, input logic odd);
        return {hi, byp, lo, odd};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [3:0] t, input logic [2:0] p, input logic [8:0] d,
                            input bit also_reconfig, input string tag);
        int ena_seen;
        int busy_seen;
        counter_type  = t;
        counter_param = p;
        data_in       = d;
        write_param   = 1'b1;
        reconfig      = also_reconfig;
        @(negedge clk);
        write_param = 1'b0;
        reconfig    = 1'b0;
        chk({tag, "_busy_hi"}, 64'(busy), 64'd1);
        @(negedge clk);
        chk({tag, "_busy_lo"}, 64'(busy), 64'd0);
        if (also_reconfig) begin
            ena_seen  = 0;
            busy_seen = 0;
            repeat (20) begin
                @(negedge clk);
                if (scanclkena) ena_seen++;
                if (busy) busy_seen++;
            end
            chk({tag, "_no_scanclkena"}, 64'(ena_seen), 64'd0);
            chk({tag, "_no_late_busy"}, 64'(busy_seen), 64'd0);
        end
    endtask

    // Runs one reconfiguration, capturing scandata on scanclk rising edges.
    task automatic run_scan(input bit hold_done, input int inject_bit, input bit inject_areset,
                            input string tag, output logic [53:0] bits);
        int n_bits     = 0;
        int shift_cyc  = 0;
        int ena_cyc    = 0;
        int cu_cyc     = 0;
        int wait_cyc   = 0;
        int since_rise = 0;
        int glitches   = 0;
        bit cu_rose    = 0;
        bit cu_fell    = 0;
        bit finished   = 0;
        bit aborted    = 0;
        logic prev_sclk  = 1'b0;
        logic prev_sdata = 1'b0;
        logic prev_cu    = 1'b0;
        logic prev_ena   = 1'b0;
        bits     = '0;
        reconfig = 1'b1;
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            @(negedge clk);
            reconfig    = 1'b0;
            write_param = 1'b0;
            if (aborted) begin
                chk({tag, "_abort_busy"}, 64'(busy), 64'd0);
                chk({tag, "_abort_ena"}, 64'(scanclkena), 64'd0);
                chk({tag, "_abort_data"}, 64'(scandata), 64'd0);
                chk({tag, "_abort_cu"}, 64'(configupdate), 64'd0);
                chk({tag, "_abort_sclk"}, 64'(scanclk), 64'd0);
                chk({tag, "_abort_pll_areset"}, 64'(pll_areset), 64'd1);
                pll_areset_in = 1'b0;
                finished      = 1;
                continue;
            end
            if (cyc == 0) begin
                chk({tag, "_start_busy"}, 64'(busy), 64'd1);
                chk({tag, "_start_timeout"}, 64'(timeout), 64'd0);
                chk({tag, "_start_sclk"}, 64'(scanclk), 64'd0);
            end
            if (scanclkena && scanclk && !prev_sclk) begin
                bits = {bits[52:0], scandata};
                n_bits++;
                if (n_bits == inject_bit) begin
                    if (inject_areset) begin
                        pll_areset_in = 1'b1;
                        aborted       = 1;
                    end else begin
                        counter_type  = 4'b0100;
                        counter_param = 3'b000;
                        data_in       = 9'h077;
                        write_param   = 1'b1;
                    end
                end
            end
            if (scanclkena) ena_cyc++;
            if (busy && !configupdate && !cu_rose) shift_cyc++;
            if (prev_ena && scanclkena && (scandata != prev_sdata) && !(prev_sclk && !scanclk))
                glitches++;
            if (configupdate) cu_cyc++;
            if (configupdate && !prev_cu) cu_rose = 1;
            if (cu_rose) since_rise++;
            if (!configupdate && prev_cu) cu_fell = 1;
            if (cu_fell && busy) wait_cyc++;
            if (!hold_done && since_rise == 10) scandone = 1'b1;
            if (!busy && !aborted) finished = 1;
            prev_sclk  = scanclk;
            prev_sdata = scandata;
            prev_cu    = configupdate;
            prev_ena   = scanclkena;
        end
        chk({tag, "_completed"}, 64'(finished), 64'd1);
        if (inject_areset) begin
            chk({tag, "_bits_before_abort"}, 64'(n_bits), 64'(inject_bit));
        end else begin
            chk({tag, "_rising_edges"}, 64'(n_bits), 64'd54);
            chk({tag, "_shift_cycles"}, 64'(shift_cyc), 64'd216);
            chk({tag, "_ena_cycles"}, 64'(ena_cyc), 64'd216);
            chk({tag, "_cu_width"}, 64'(cu_cyc), 64'd4);
            chk({tag, "_data_stable"}, 64'(glitches), 64'd0);
            if (hold_done) begin
                chk({tag, "_wait_cycles"}, 64'(wait_cyc), 64'd1023);
                chk({tag, "_timeout_set"}, 64'(timeout), 64'd1);
            end else begin
                chk({tag, "_timeout_clear"}, 64'(timeout), 64'd0);
            end
        end
        scandone = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    logic [53:0] got;
    logic [53:0] got_b;
    logic [53:0] cur;

    initial begin
        // Cumulative shadow state after each write, hand-computed
        vecs[0]  = '{4'b0001, 3'b111, 9'd13,
                     {rec(8'h06, 0, 8'h06, 0), rec(8'h07, 0, 8'h06, 1), rec(8'h01, 1, 8'h01, 0)}};
        vecs[1]  = '{4'b0100, 3'b000, 9'h020,
                     {rec(8'h20, 0, 8'h06, 0), rec(8'h07, 0, 8'h06, 1), rec(8'h01, 1, 8'h01, 0)}};
        vecs[2]  = '{4'b0000, 3'b001, 9'h05A,
                     {rec(8'h20, 0, 8'h06, 0), rec(8'h07, 0, 8'h06, 1), rec(8'h01, 1, 8'h5A, 0)}};
        vecs[3]  = '{4'b0000, 3'b100, 9'h000,
                     {rec(8'h20, 0, 8'h06, 0), rec(8'h07, 0, 8'h06, 1), rec(8'h01, 0, 8'h5A, 0)}};
        vecs[4]  = '{4'b0100, 3'b101, 9'h001,
                     {rec(8'h20, 0, 8'h06, 1), rec(8'h07, 0, 8'h06, 1), rec(8'h01, 0, 8'h5A, 0)}};
        vecs[5]  = '{4'b0001, 3'b111, 9'd1,
                     {rec(8'h20, 0, 8'h06, 1), rec(8'h07, 1, 8'h06, 1), rec(8'h01, 0, 8'h5A, 0)}};
        vecs[6]  = '{4'b0001, 3'b111, 9'd0,
                     {rec(8'h20, 0, 8'h06, 1), rec(8'h07, 1, 8'h06, 1), rec(8'h01, 0, 8'h5A, 0)}};
        vecs[7]  = '{4'b0100, 3'b111, 9'h1FF,
                     {rec(8'h00, 0, 8'hFF, 1), rec(8'h07, 1, 8'h06, 1), rec(8'h01, 0, 8'h5A, 0)}};
        vecs[8]  = '{4'b0010, 3'b000, 9'h033,
                     {rec(8'h00, 0, 8'hFF, 1), rec(8'h07, 1, 8'h06, 1), rec(8'h01, 0, 8'h5A, 0)}};
        vecs[9]  = '{4'b0000, 3'b010, 9'h044,
                     {rec(8'h00, 0, 8'hFF, 1), rec(8'h07, 1, 8'h06, 1), rec(8'h01, 0, 8'h5A, 0)}};
        vecs[10] = '{4'b0000, 3'b000, 9'h100,
                     {rec(8'h00, 0, 8'hFF, 1), rec(8'h07, 1, 8'h06, 1), rec(8'h00, 0, 8'h5A, 0)}};

        reset         = 1'b1;
        write_param   = 1'b0;
        reconfig      = 1'b0;
        counter_type  = 4'b0000;
        counter_param = 3'b000;
        data_in       = 9'd0;
        pll_areset_in = 1'b0;
        scandone      = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_timeout", 64'(timeout), 64'd0);
        chk("reset_scan_outputs", 64'({scanclk, scanclkena, scandata, configupdate}), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run_scan(0, -1, 0, "reset_scan", got);
        chk("reset_scan_chain", 64'(got),
            64'({rec(8'h06, 0, 8'h06, 0), rec(8'h06, 0, 8'h06, 0), rec(8'h01, 1, 8'h01, 0)}));

        for (int i = 0; i < 11; i++) begin
            do_write(vecs[i].ctype, vecs[i].cparam, vecs[i].data, 0, $sformatf("vec%0d", i));
            run_scan(0, -1, 0, $sformatf("vec%0d", i), got);
            chk($sformatf("vec%0d_chain", i), 64'(got), 64'(vecs[i].exp_chain));
        end

        // Write wins over a simultaneous reconfig: N odd becomes 1, no scan starts
        do_write(4'b0000, 3'b101, 9'h001, 1, "write_and_reconfig");
        cur = {rec(8'h00, 0, 8'hFF, 1), rec(8'h07, 1, 8'h06, 1), rec(8'h00, 0, 8'h5A, 1)};

        run_scan(0, 10, 0, "midscan_write", got);
        run_scan(0, -1, 0, "midscan_readback", got_b);
        chk("midscan_chain", 64'(got), 64'(cur));
        chk("midscan_identical", 64'(got_b), 64'(got));

        run_scan(1, -1, 0, "timeout_scan", got);
        chk("timeout_scan_chain", 64'(got), 64'(cur));
        run_scan(0, -1, 0, "after_timeout", got);
        chk("after_timeout_chain", 64'(got), 64'(cur));

        run_scan(0, 20, 1, "areset", got);
        chk("areset_timeout_kept", 64'(timeout), 64'd0);
        run_scan(0, -1, 0, "after_areset", got);
        chk("after_areset_chain", 64'(got), 64'(cur));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
